// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared 640x480@60 Hz raster constants (porches, sync widths,
//                totals) and the pixel-coordinate width. Imported by the
//                timing generator and by every downstream pixel generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Width of pix_x / pix_y; both totals must fit in this many bits.
    localparam int PIX_W = 10;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Pixel rate divider for a 100 MHz system clock (25 MHz pixels).
    localparam int VGA_CLK_DIV   = 4;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/pixel_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_tick_gen
//  Description : Free-running clock divider producing a one-clk pixel enable
//                every CLK_DIV clocks. p_tick_o is decoded from the divider
//                register only, so it is glitch-free and aligned to it.
//  Ports       : clk       in   system clock
//                reset     in   synchronous, active-high
//                p_tick_o  out  pixel enable (1 clk wide, period CLK_DIV)
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick_o
);

    generate
        if (CLK_DIV <= 1) begin : g_div1
            // Every clock is a pixel clock: no divider state is needed.
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, reset};
            assign p_tick_o  = 1'b1;
        end else begin : g_divn
            localparam int             DW     = $clog2(CLK_DIV);
            localparam logic [DW-1:0]  C_LAST = DW'(CLK_DIV - 1);

            logic [DW-1:0] d_q;
            logic [DW-1:0] d_d;

            always_comb begin
                d_d = (d_q == C_LAST) ? '0 : d_q + 1'b1;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    d_q <= '0;
                end else begin
                    d_q <= d_d;
                end
            end

            assign p_tick_o = (d_q == C_LAST);
        end
    endgenerate

endmodule : pixel_tick_gen
`default_nettype wire

// File: rtl/vga_sync_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_timing
//  Description : VGA raster timing generator. Horizontal/vertical pixel
//                counters advance on each pixel tick; all decoded outputs
//                (video_on, syncs, strobes) are registered from the counters'
//                next state so they switch on the same edge as pix_x/pix_y.
//  Ports       : clk            in   system clock
//                reset          in   synchronous, active-high
//                p_tick_o       out  pixel enable, once per CLK_DIV clks
//                pix_x_o        out  horizontal count 0..H_TOTAL-1
//                pix_y_o        out  vertical count 0..V_TOTAL-1
//                video_on_o     out  visible-area flag
//                hsync_o        out  horizontal sync, active low
//                vsync_o        out  vertical sync, active low
//                line_start_o   out  1 clk pulse at the start of pix_x==0
//                frame_start_o  out  1 clk pulse at the start of (0,0)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_timing
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = VGA_CLK_DIV,
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic             clk,
    input  logic             reset,
    output logic             p_tick_o,
    output logic [PIX_W-1:0] pix_x_o,
    output logic [PIX_W-1:0] pix_y_o,
    output logic             video_on_o,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             line_start_o,
    output logic             frame_start_o
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    generate
        if ((H_TOTAL > (1 << PIX_W)) || (V_TOTAL > (1 << PIX_W)) || (CLK_DIV < 1)) begin : g_param_check
            $error("vga_sync_timing: totals exceed pixel counter range or CLK_DIV < 1");
        end
    endgenerate

    localparam logic [PIX_W-1:0] C_H_LAST     = PIX_W'(H_TOTAL - 1);
    localparam logic [PIX_W-1:0] C_V_LAST     = PIX_W'(V_TOTAL - 1);
    localparam logic [PIX_W-1:0] C_H_DISP     = PIX_W'(H_DISPLAY);
    localparam logic [PIX_W-1:0] C_V_DISP     = PIX_W'(V_DISPLAY);
    localparam logic [PIX_W-1:0] C_HS_FIRST   = PIX_W'(H_DISPLAY + H_FRONT);
    localparam logic [PIX_W-1:0] C_HS_LAST    = PIX_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [PIX_W-1:0] C_VS_FIRST   = PIX_W'(V_DISPLAY + V_FRONT);
    localparam logic [PIX_W-1:0] C_VS_LAST    = PIX_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic             p_tick_w;
    logic             h_wrap_w;
    logic             v_wrap_w;

    logic [PIX_W-1:0] h_q, h_d;
    logic [PIX_W-1:0] v_q, v_d;
    logic             video_on_q, video_on_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .p_tick_o (p_tick_w)
    );

    assign h_wrap_w = (h_q == C_H_LAST);
    assign v_wrap_w = (v_q == C_V_LAST);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (p_tick_w) begin
            h_d = h_wrap_w ? '0 : h_q + 1'b1;
            if (h_wrap_w) begin
                v_d = v_wrap_w ? '0 : v_q + 1'b1;
            end
        end

        // Decoding the next-state counters lets these flops switch on the
        // same edge as pix_x/pix_y, so there is no skew between outputs.
        video_on_d    = (h_d < C_H_DISP) && (v_d < C_V_DISP);
        hsync_d       = !((h_d >= C_HS_FIRST) && (h_d <= C_HS_LAST));
        vsync_d       = !((v_d >= C_VS_FIRST) && (v_d <= C_VS_LAST));

        // Strobes only fire on the advancing edge, hence one clk wide.
        line_start_d  = p_tick_w && h_wrap_w;
        frame_start_d = p_tick_w && h_wrap_w && v_wrap_w;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Parked on the last pixel so the first tick lands on (0,0)
            // and produces a clean frame start.
            h_q           <= C_H_LAST;
            v_q           <= C_V_LAST;
            video_on_q    <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign p_tick_o      = p_tick_w;
    assign pix_x_o       = h_q;
    assign pix_y_o       = v_q;
    assign video_on_o    = video_on_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign line_start_o  = line_start_q;
    assign frame_start_o = frame_start_q;

endmodule : vga_sync_timing
`default_nettype wire

// File: tb/tb_vga_sync_timing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_timing
//  Description : Self-checking bench for vga_sync_timing. Three instances:
//                A = 640x480 with CLK_DIV=4, B = 640x480 with CLK_DIV=1,
//                C = tiny 15x9 raster with CLK_DIV=3 (full frames quickly).
//                A raster-position model derived from clocks-since-reset
//                predicts every output each cycle; directed literals and
//                measured periods/widths pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA = 1'b1, rstB = 1'b1, rstC = 1'b1;

    logic       ptA, vidA, hsA, vsA, lsA, fsA;
    logic [9:0] pxA, pyA;
    logic       ptB, vidB, hsB, vsB, lsB, fsB;
    logic [9:0] pxB, pyB;
    logic       ptC, vidC, hsC, vsC, lsC, fsC;
    logic [9:0] pxC, pyC;

    vga_sync_timing #(.CLK_DIV(4)) dutA (
        .clk(clk), .reset(rstA), .p_tick_o(ptA), .pix_x_o(pxA), .pix_y_o(pyA),
        .video_on_o(vidA), .hsync_o(hsA), .vsync_o(vsA),
        .line_start_o(lsA), .frame_start_o(fsA));

    vga_sync_timing #(.CLK_DIV(1)) dutB (
        .clk(clk), .reset(rstB), .p_tick_o(ptB), .pix_x_o(pxB), .pix_y_o(pyB),
        .video_on_o(vidB), .hsync_o(hsB), .vsync_o(vsB),
        .line_start_o(lsB), .frame_start_o(fsB));

    vga_sync_timing #(
        .CLK_DIV(3), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
    ) dutC (
        .clk(clk), .reset(rstC), .p_tick_o(ptC), .pix_x_o(pxC), .pix_y_o(pyC),
        .video_on_o(vidC), .hsync_o(hsC), .vsync_o(vsC),
        .line_start_o(lsC), .frame_start_o(fsC));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       pt;
        logic [9:0] x;
        logic [9:0] y;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } obs_t;

    // Raster model: after cnt clocks out of reset, floor(cnt/div) pixel
    // advances have happened; advance n (n>=1) shows pixel n-1 of the
    // raster in row-major order, starting a new pixel when cnt%div==0.
    function automatic obs_t model(int cnt, int div, int hd, int hf, int hsw, int hb,
                                   int vd, int vf, int vsw, int vb);
        obs_t e;
        int   htot;
        int   vtot;
        int   adv;
        int   idx;
        int   x;
        int   y;
        bit   fresh;
        htot = hd + hf + hsw + hb;
        vtot = vd + vf + vsw + vb;
        adv  = cnt / div;
        if (adv == 0) begin
            x     = htot - 1;
            y     = vtot - 1;
            fresh = 1'b0;
        end else begin
            idx   = (adv - 1) % (htot * vtot);
            x     = idx % htot;
            y     = idx / htot;
            fresh = ((cnt % div) == 0);
        end
        e.pt  = ((cnt % div) == (div - 1));
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.vid = (x < hd) && (y < vd);
        e.hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
        e.vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
        e.ls  = fresh && (x == 0);
        e.fs  = fresh && (x == 0) && (y == 0);
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cmp(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: actual pt=%b x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b required pt=%b x=%0d y=%0d vid=%b hs=%b vs=%b ls=%b fs=%b",
                     name, $time, act.pt, act.x, act.y, act.vid, act.hs, act.vs, act.ls, act.fs,
                     exp.pt, exp.x, exp.y, exp.vid, exp.hs, exp.vs, exp.ls, exp.fs);
        end
    endtask

    // Clocks since the last reset edge, per instance.
    int cntA = 0, cntB = 0, cntC = 0;
    always @(posedge clk) begin
        cntA <= rstA ? 0 : cntA + 1;
        cntB <= rstB ? 0 : cntB + 1;
        cntC <= rstC ? 0 : cntC + 1;
    end

    obs_t obsA, obsB, obsC;
    assign obsA = {ptA, pxA, pyA, vidA, hsA, vsA, lsA, fsA};
    assign obsB = {ptB, pxB, pyB, vidB, hsB, vsB, lsB, fsB};
    assign obsC = {ptC, pxC, pyC, vidC, hsC, vsC, lsC, fsC};

    // Single compare process: every cycle, every instance.
    always @(negedge clk) begin
        cmp("modelA", obsA, model(cntA, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        cmp("modelB", obsB, model(cntB, 1, 640, 16, 96, 48, 480, 10, 2, 33));
        cmp("modelC", obsC, model(cntC, 3, 8, 2, 3, 2, 4, 1, 2, 2));
    end

    // Measurements for instance A (line period, hsync/video widths, edges).
    int   lnClkA = 0, lnHsA = 0, lnVidA = 0;
    bit   seenA = 1'b0;
    int   perA = -1, hsLowA = -1, vidClkA = -1;
    int   fallXA = -1, preFallXA = -1, hsFirstA = -1, hsLastA = -1;
    logic prevVidA = 1'b0, prevHsA = 1'b1;
    logic [9:0] prevXA = '0;
    always @(negedge clk) begin
        prevVidA <= vidA;
        prevHsA  <= hsA;
        prevXA   <= pxA;
        if (prevVidA && !vidA) begin
            fallXA    <= int'(pxA);
            preFallXA <= int'(prevXA);
        end
        if (prevHsA && !hsA) hsFirstA <= int'(pxA);
        if (!prevHsA && hsA && !rstA) hsLastA <= int'(prevXA);
        if (rstA) begin
            seenA <= 1'b0;
        end else if (lsA) begin
            if (seenA) begin
                perA    <= lnClkA;
                hsLowA  <= lnHsA;
                vidClkA <= lnVidA;
            end
            seenA  <= 1'b1;
            lnClkA <= 1;
            lnHsA  <= int'(!hsA);
            lnVidA <= int'(vidA);
        end else begin
            lnClkA <= lnClkA + 1;
            lnHsA  <= lnHsA + int'(!hsA);
            lnVidA <= lnVidA + int'(vidA);
        end
    end

    // Measurements for instance B (line period, hsync width in clocks).
    int lnClkB = 0, lnHsB = 0, perB = -1, hsLowB = -1;
    bit seenB = 1'b0;
    always @(negedge clk) begin
        if (rstB) begin
            seenB <= 1'b0;
        end else if (lsB) begin
            if (seenB) begin
                perB   <= lnClkB;
                hsLowB <= lnHsB;
            end
            seenB  <= 1'b1;
            lnClkB <= 1;
            lnHsB  <= int'(!hsB);
        end else begin
            lnClkB <= lnClkB + 1;
            lnHsB  <= lnHsB + int'(!hsB);
        end
    end

    // Measurements for instance C (frame period, vsync/video totals).
    int frClkC = 0, frVsC = 0, frVidC = 0, perC = -1, vsLowC = -1, vidFrC = -1;
    int fcC = 0, fsLsC = 0;
    bit seenC = 1'b0;
    always @(negedge clk) begin
        if (fsC) begin
            fcC <= fcC + 1;
            if (lsC) fsLsC <= fsLsC + 1;
        end
        if (rstC) begin
            seenC <= 1'b0;
        end else if (fsC) begin
            if (seenC) begin
                perC   <= frClkC;
                vsLowC <= frVsC;
                vidFrC <= frVidC;
            end
            seenC  <= 1'b1;
            frClkC <= 1;
            frVsC  <= int'(!vsC);
            frVidC <= int'(vidC);
        end else begin
            frClkC <= frClkC + 1;
            frVsC  <= frVsC + int'(!vsC);
            frVidC <= frVidC + int'(vidC);
        end
    end

    // Release-from-reset sequence of instance A: k clocks after release.
    task automatic scen1(string tag);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check({tag, "_ptick"}, int'(ptA), ((k % 4) == 3) ? 1 : 0);
            if (k == 4) begin
                check({tag, "_x0"},   int'(pxA),  0);
                check({tag, "_y0"},   int'(pyA),  0);
                check({tag, "_vid"},  int'(vidA), 1);
                check({tag, "_ls"},   int'(lsA),  1);
                check({tag, "_fs"},   int'(fsA),  1);
            end
            if (k == 5) begin
                check({tag, "_ls_drop"}, int'(lsA), 0);
                check({tag, "_fs_drop"}, int'(fsA), 0);
                check({tag, "_x_hold"},  int'(pxA), 0);
            end
            if (k == 8) check({tag, "_x1"}, int'(pxA), 1);
        end
    endtask

    bit found;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_x",     int'(pxA),  799);
        check("rst_y",     int'(pyA),  524);
        check("rst_vid",   int'(vidA), 0);
        check("rst_hs",    int'(hsA),  1);
        check("rst_vs",    int'(vsA),  1);
        check("rst_ptick", int'(ptA),  0);
        check("rst_ls",    int'(lsA),  0);
        check("rst_fs",    int'(fsA),  0);
        check("rst_B_ptick_const", int'(ptB), 1);
        check("rst_C_x",   int'(pxC),  14);
        check("rst_C_y",   int'(pyC),  8);

        rstA = 1'b0;
        rstB = 1'b0;
        rstC = 1'b0;
        scen1("s1");

        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            @(negedge clk);
            if (pxA == 10'd300 && pyA == 10'd2) found = 1'b1;
        end
        check("reach_300_2", int'(found), 1);

        // One clock into pixel 300, so the divider is mid-count.
        @(negedge clk);
        rstA = 1'b1;
        rstC = 1'b1;
        @(negedge clk);
        check("mid_rst_x",     int'(pxA),  799);
        check("mid_rst_y",     int'(pyA),  524);
        check("mid_rst_vid",   int'(vidA), 0);
        check("mid_rst_hs",    int'(hsA),  1);
        check("mid_rst_vs",    int'(vsA),  1);
        check("mid_rst_ptick", int'(ptA),  0);
        check("mid_rst_ls",    int'(lsA),  0);
        check("mid_rst_fs",    int'(fsA),  0);
        check("mid_rst_C_x",   int'(pxC),  14);
        @(negedge clk);
        rstA = 1'b0;
        rstC = 1'b0;
        scen1("s5");

        repeat (10400) @(negedge clk);

        check("A_line_clks",     perA,      3200);
        check("A_hsync_clks",    hsLowA,    384);
        check("A_video_clks",    vidClkA,   2560);
        check("A_video_fall_x",  fallXA,    640);
        check("A_video_last_x",  preFallXA, 639);
        check("A_hsync_first_x", hsFirstA,  656);
        check("A_hsync_last_x",  hsLastA,   751);
        check("B_line_clks",     perB,      800);
        check("B_hsync_clks",    hsLowB,    96);
        check("C_frame_clks",    perC,      405);
        check("C_vsync_clks",    vsLowC,    90);
        check("C_video_clks",    vidFrC,    96);
        check("C_frames_seen",   int'(fcC >= 20), 1);
        check("C_fs_with_ls",    fsLsC,     fcC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_vga_sync_timing
`default_nettype wire
